decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register/operand data width.
REQ-002 SHALL have parameter NREGS, default 16, register-file depth (4-bit index).
REQ-003 SHALL have ports clk (in, 1, sole clock) and reset (in, 1, asynchronous active-low reset).
REQ-004 SHALL have inputs InstrD (17, instruction), PCD (12, its PC) and PCPlus4D (12, PC+1), all from the fetch pipeline register.
REQ-005 SHALL have inputs StallD (1, hold the D->E register) and FlushE (1, load a bubble into the D->E register).
REQ-006 SHALL have write-back inputs RegWriteW (1), RdW (4) and ResultW (DATA_W).
REQ-007 SHALL have outputs Rs1D and Rs2D (4 each), combinational source indices for the hazard unit.
REQ-008 SHALL have registered outputs RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchE, JumpE and IllegalE (1 each).
REQ-009 SHALL have registered outputs ALUControlE (3), RD1E and RD2E (DATA_W), ImmExtE (DATA_W), RdE, Rs1E and Rs2E (4 each), and PCE and PCPlus4E (12 each).

Function
REQ-010 SHALL split fields as opcode=InstrD[16:13], rd=[12:9], rs1=[8:5], rs2=[4:1], imm5=[4:0], imm12=[11:0].
REQ-011 SHALL decode opcodes as: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 ADDI; 6 LD; 7 ST; 8 BEQ; 9 JMP.
REQ-012 SHALL use ALUControl 000 for ADD/ADDI/LD/ST/JMP, 001 for SUB/BEQ, 010 for AND and 011 for OR.
REQ-013 SHALL assert RegWrite for ADD/SUB/AND/OR/ADDI/LD, MemWrite for ST, MemtoReg for LD, ALUSrc for ADDI/LD/ST, Branch for BEQ and Jump for JMP.
REQ-014 SHALL, for ST and BEQ, take Rs2D from the rd field [12:9]; otherwise Rs2D=[4:1].
REQ-015 SHALL set ImmExt to sign-extend(imm5) for ADDI/LD/ST/BEQ, sign-extend(imm12) for JMP, and 0 otherwise.
REQ-016 SHALL force RdE=0 when RegWrite is 0.
REQ-017 SHALL, for opcodes 10-15, drive all control bits and ALUControl to 0 and set IllegalE=1 for that instruction.
REQ-018 SHALL implement the register file as NREGS x DATA_W, written at the posedge when RegWriteW=1 and RdW!=0.
REQ-019 SHALL make register 0 always read 0 and ignore writes to it.
REQ-020 SHALL bypass writes: when RegWriteW=1, RdW!=0 and RdW equals a read index, the read port returns ResultW in the same cycle.
REQ-021 SHALL capture all decoded values into the D->E register at each posedge, giving a latency of exactly 1 cycle.
REQ-022 SHALL, when FlushE=1, load all D->E fields with 0 (bubble), regardless of StallD.
REQ-023 SHALL, when StallD=1 and FlushE=0, hold the D->E register unchanged.
REQ-024 SHALL allow register-file writes to proceed during stall and flush.

Reset
REQ-025 SHALL, when reset=0, immediately clear every D->E field to 0 (all E outputs 0) and every register-file entry to 0.
REQ-026 SHALL take its first capture at the first posedge after reset deasserts; reset mid-stall or mid-flush SHALL override both.

Structure
REQ-027 SHALL place opcode constants, ALUControl encodings, field bit positions and the D->E record typedef in a shared package decode_pkg.
REQ-028 SHALL implement the register file as a single sub-module register_file (2 async read ports, 1 sync write port, internal bypass).

Verification
REQ-029 SHALL verify: reset low, then high; InstrD=ADD r3,r1,r2 -> next cycle RegWriteE=1, ALUControlE=000, RdE=3, RD1E=RD2E=0.
REQ-030 SHALL verify: write r1=0x0005 via W while InstrD=ADDI r2,r1,-1 (imm5=0x1F) in the same cycle -> RD1E=0x0005 (bypass), ImmExtE=0xFFFF, ALUSrcE=1.
REQ-031 SHALL verify: RegWriteW=1, RdW=0, ResultW=0x1234, then read r0 -> RD1E=0x0000.
REQ-032 SHALL verify: StallD=1 for 2 cycles while InstrD changes -> E outputs unchanged; with StallD=1 and FlushE=1 -> all E outputs 0.
REQ-033 SHALL verify: InstrD opcode 0xB -> IllegalE=1, RegWriteE=MemWriteE=0; JMP with imm12=0x800 -> JumpE=1, ImmExtE=0xF800.
REQ-034 SHALL verify: reset=0 asserted between clock edges -> all E outputs are 0 before the next posedge.

Source files
------------

// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode stage: instruction field positions,
// opcode and ALU-control encodings, the decoded control record, the D->E
// pipeline record and the opcode decoder function.
// No ports (package).
// -----------------------------------------------------------------------------
package decode_pkg;

    localparam int INSTR_W   = 17;
    localparam int PC_W      = 12;
    localparam int REG_IDX_W = 4;
    localparam int ALU_W     = 3;

    // Instruction field positions
    localparam int OPC_HI   = 16;
    localparam int OPC_LO   = 13;
    localparam int RD_HI    = 12;
    localparam int RD_LO    = 9;
    localparam int RS1_HI   = 8;
    localparam int RS1_LO   = 5;
    localparam int RS2_HI   = 4;
    localparam int RS2_LO   = 1;
    localparam int IMM5_HI  = 4;
    localparam int IMM5_LO  = 0;
    localparam int IMM12_HI = 11;
    localparam int IMM12_LO = 0;

    // Opcodes 10..15 are unassigned and decode as illegal.
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_ADDI = 4'd5,
        OP_LD   = 4'd6,
        OP_ST   = 4'd7,
        OP_BEQ  = 4'd8,
        OP_JMP  = 4'd9
    } opcode_e;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_5    = 2'd1,
        IMM_12   = 2'd2
    } imm_sel_e;

    // Decoded control bits for one instruction.
    typedef struct packed {
        logic      reg_write;
        logic      mem_write;
        logic      mem_to_reg;
        logic      alu_src;
        logic      branch;
        logic      jump;
        logic      illegal;
        alu_ctrl_e alu_ctrl;
    } ctrl_t;

    // D->E pipeline record. The data-width dependent fields (RD1, RD2,
    // ImmExt) live next to this record in the stage because their width is
    // a module parameter.
    typedef struct packed {
        ctrl_t                 ctrl;
        logic [REG_IDX_W-1:0]  rd;
        logic [REG_IDX_W-1:0]  rs1;
        logic [REG_IDX_W-1:0]  rs2;
        logic [PC_W-1:0]       pc;
        logic [PC_W-1:0]       pc_plus4;
    } de_reg_t;

    // Opcode -> control bits. Unassigned opcodes leave every control bit
    // and ALU control at zero and only raise illegal.
    function automatic ctrl_t decode_ctrl(input opcode_e op);
        ctrl_t c;
        c = '0;
        c.alu_ctrl = ALU_ADD;
        case (op)
            OP_NOP:  ;
            OP_ADD:  c.reg_write = 1'b1;
            OP_SUB:  begin c.reg_write = 1'b1; c.alu_ctrl = ALU_SUB; end
            OP_AND:  begin c.reg_write = 1'b1; c.alu_ctrl = ALU_AND; end
            OP_OR:   begin c.reg_write = 1'b1; c.alu_ctrl = ALU_OR;  end
            OP_ADDI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
            OP_LD:   begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
            end
            OP_ST:   begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
            OP_BEQ:  begin c.branch = 1'b1; c.alu_ctrl = ALU_SUB; end
            OP_JMP:  c.jump = 1'b1;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // Which immediate format an opcode uses.
    function automatic imm_sel_e decode_imm_sel(input opcode_e op);
        imm_sel_e s;
        case (op)
            OP_ADDI, OP_LD, OP_ST, OP_BEQ: s = IMM_5;
            OP_JMP:                        s = IMM_12;
            default:                       s = IMM_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
// Bundles every non-clock signal of the decode stage.
//   Fetch side   : InstrD, PCD, PCPlus4D
//   Hazard side  : StallD, FlushE (in), Rs1D, Rs2D (out, combinational)
//   Write-back   : RegWriteW, RdW, ResultW
//   Execute side : registered D->E outputs (*E)
// Modports:
//   master - surrounding pipeline (drives fetch/hazard/write-back inputs)
//   slave  - the decode stage itself
// There is no valid/ready handshake: the stage captures every cycle unless
// StallD holds it or FlushE clears it, and FlushE always wins over StallD.
// -----------------------------------------------------------------------------
interface decode_stage_if #(
    parameter int DATA_W = 16
);
    logic [16:0]       InstrD;
    logic [11:0]       PCD;
    logic [11:0]       PCPlus4D;
    logic              StallD;
    logic              FlushE;
    logic              RegWriteW;
    logic [3:0]        RdW;
    logic [DATA_W-1:0] ResultW;

    logic [3:0]        Rs1D;
    logic [3:0]        Rs2D;

    logic              RegWriteE;
    logic              MemWriteE;
    logic              MemtoRegE;
    logic              ALUSrcE;
    logic              BranchE;
    logic              JumpE;
    logic              IllegalE;
    logic [2:0]        ALUControlE;
    logic [DATA_W-1:0] RD1E;
    logic [DATA_W-1:0] RD2E;
    logic [DATA_W-1:0] ImmExtE;
    logic [3:0]        RdE;
    logic [3:0]        Rs1E;
    logic [3:0]        Rs2E;
    logic [11:0]       PCE;
    logic [11:0]       PCPlus4E;

    modport master (
        output InstrD, PCD, PCPlus4D, StallD, FlushE,
               RegWriteW, RdW, ResultW,
        input  Rs1D, Rs2D,
               RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchE, JumpE,
               IllegalE, ALUControlE, RD1E, RD2E, ImmExtE, RdE, Rs1E, Rs2E,
               PCE, PCPlus4E
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, StallD, FlushE,
               RegWriteW, RdW, ResultW,
        output Rs1D, Rs2D,
               RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchE, JumpE,
               IllegalE, ALUControlE, RD1E, RD2E, ImmExtE, RdE, Rs1E, Rs2E,
               PCE, PCPlus4E
    );
endinterface

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// NREGS x DATA_W register file, two asynchronous read ports, one synchronous
// write port. Register 0 reads as zero and ignores writes. A write in flight
// is forwarded to a read port addressing the same register in the same cycle.
// Ports:
//   clk, reset         - clock, asynchronous active-low reset (clears all)
//   we, waddr, wdata   - write port (posedge)
//   raddr1, rdata1     - read port 1
//   raddr2, rdata2     - read port 2
// -----------------------------------------------------------------------------
module register_file
    import decode_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [DATA_W-1:0]    rdata1,
    output logic [DATA_W-1:0]    rdata2
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_active;

    // A write to r0 is a no-op everywhere, including the bypass.
    assign wr_active = we && (waddr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (wr_active && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (wr_active && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Pipeline decode stage: splits the instruction, decodes control bits,
// reads the register file (with write-back bypass), sign-extends the
// immediate and registers everything into the D->E pipeline register.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset; clears the D->E register and
//            the register file
//   bus    - decode_stage_if.slave (fetch inputs, hazard controls,
//            write-back port, Rs1D/Rs2D and all registered *E outputs)
// D->E register priority: reset, then FlushE (bubble), then StallD (hold),
// else capture.
// -----------------------------------------------------------------------------
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic               clk,
    input  logic               reset,
    decode_stage_if.slave      bus
);

    // ---------------- field split ----------------
    opcode_e              opcode_d;
    logic [REG_IDX_W-1:0] rd_field;
    logic [REG_IDX_W-1:0] rs1_d;
    logic [REG_IDX_W-1:0] rs2_field;
    logic [REG_IDX_W-1:0] rs2_d;
    logic [4:0]           imm5;
    logic [11:0]          imm12;

    assign opcode_d  = opcode_e'(bus.InstrD[OPC_HI:OPC_LO]);
    assign rd_field  = bus.InstrD[RD_HI:RD_LO];
    assign rs1_d     = bus.InstrD[RS1_HI:RS1_LO];
    assign rs2_field = bus.InstrD[RS2_HI:RS2_LO];
    assign imm5      = bus.InstrD[IMM5_HI:IMM5_LO];
    assign imm12     = bus.InstrD[IMM12_HI:IMM12_LO];

    // ST and BEQ have no destination; their rd field names the second source
    // (store data / compare operand).
    assign rs2_d = ((opcode_d == OP_ST) || (opcode_d == OP_BEQ)) ? rd_field
                                                                 : rs2_field;

    assign bus.Rs1D = rs1_d;
    assign bus.Rs2D = rs2_d;

    // ---------------- control decode ----------------
    ctrl_t                ctrl_d;
    imm_sel_e             imm_sel_d;
    logic [DATA_W-1:0]    imm_ext_d;
    logic [REG_IDX_W-1:0] rd_d;

    assign ctrl_d    = decode_ctrl(opcode_d);
    assign imm_sel_d = decode_imm_sel(opcode_d);

    always_comb begin
        imm_ext_d = '0;
        case (imm_sel_d)
            IMM_5:   imm_ext_d = {{(DATA_W-5){imm5[4]}}, imm5};
            IMM_12:  imm_ext_d = {{(DATA_W-12){imm12[11]}}, imm12};
            default: imm_ext_d = '0;
        endcase
    end

    // A non-writing instruction carries rd=0 so the hazard unit never sees
    // a false destination match.
    assign rd_d = ctrl_d.reg_write ? rd_field : '0;

    // ---------------- register file ----------------
    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_d;

    register_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_register_file (
        .clk    (clk),
        .reset  (reset),
        .we     (bus.RegWriteW),
        .waddr  (bus.RdW),
        .wdata  (bus.ResultW),
        .raddr1 (rs1_d),
        .raddr2 (rs2_d),
        .rdata1 (rd1_d),
        .rdata2 (rd2_d)
    );

    // ---------------- D->E pipeline register ----------------
    de_reg_t           de_d;
    de_reg_t           de_q;
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;
    logic [DATA_W-1:0] imm_q;

    always_comb begin
        de_d          = '0;
        de_d.ctrl     = ctrl_d;
        de_d.rd       = rd_d;
        de_d.rs1      = rs1_d;
        de_d.rs2      = rs2_d;
        de_d.pc       = bus.PCD;
        de_d.pc_plus4 = bus.PCPlus4D;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_q  <= '0;
            rd1_q <= '0;
            rd2_q <= '0;
            imm_q <= '0;
        end else if (bus.FlushE) begin
            de_q  <= '0;
            rd1_q <= '0;
            rd2_q <= '0;
            imm_q <= '0;
        end else if (!bus.StallD) begin
            de_q  <= de_d;
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
            imm_q <= imm_ext_d;
        end
    end

    // ---------------- outputs ----------------
    assign bus.RegWriteE   = de_q.ctrl.reg_write;
    assign bus.MemWriteE   = de_q.ctrl.mem_write;
    assign bus.MemtoRegE   = de_q.ctrl.mem_to_reg;
    assign bus.ALUSrcE     = de_q.ctrl.alu_src;
    assign bus.BranchE     = de_q.ctrl.branch;
    assign bus.JumpE       = de_q.ctrl.jump;
    assign bus.IllegalE    = de_q.ctrl.illegal;
    assign bus.ALUControlE = de_q.ctrl.alu_ctrl;
    assign bus.RD1E        = rd1_q;
    assign bus.RD2E        = rd2_q;
    assign bus.ImmExtE     = imm_q;
    assign bus.RdE         = de_q.rd;
    assign bus.Rs1E        = de_q.rs1;
    assign bus.Rs2E        = de_q.rs2;
    assign bus.PCE         = de_q.pc;
    assign bus.PCPlus4E    = de_q.pc_plus4;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage. Directed instructions are issued at
// the falling edge; the hand-computed D->E record expected after the next
// rising edge is pushed into exp_q, and a monitor pops and compares it just
// after that rising edge. A few combinational / asynchronous-reset checks
// are made inline.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int DATA_W = 16;
    localparam int NREGS  = 16;
    localparam int EXP_W  = 94;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    decode_stage_if #(.DATA_W(DATA_W)) dif ();

    decode_stage #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    string            name_q[$];
    int               checks;
    int               errors;
    logic [EXP_W-1:0] act;

    assign act = {dif.RegWriteE, dif.MemWriteE, dif.MemtoRegE, dif.ALUSrcE,
                  dif.BranchE, dif.JumpE, dif.IllegalE, dif.ALUControlE,
                  dif.RD1E, dif.RD2E, dif.ImmExtE, dif.RdE, dif.Rs1E,
                  dif.Rs2E, dif.PCE, dif.PCPlus4E};

    // ctrl bit order: {RegWrite, MemWrite, MemtoReg, ALUSrc, Branch, Jump, Illegal}
    function automatic logic [EXP_W-1:0] mk(
        input logic [6:0]  c,
        input logic [2:0]  alu,
        input logic [15:0] rd1,
        input logic [15:0] rd2,
        input logic [15:0] imm,
        input logic [3:0]  rd,
        input logic [3:0]  rs1,
        input logic [3:0]  rs2,
        input logic [11:0] pc
    );
        logic [11:0] pc4;
        pc4 = pc + 12'd1;
        return {c, alu, rd1, rd2, imm, rd, rs1, rs2, pc, pc4};
    endfunction

    task automatic check_val(input string name, input logic [EXP_W-1:0] got,
                             input logic [EXP_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: the stage presents a new D->E record every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                check_val(name_q.pop_front(), act, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(
        input logic [16:0] instr,
        input logic [11:0] pc,
        input logic        rw,
        input logic [3:0]  rdw,
        input logic [15:0] res,
        input logic        stall,
        input logic        flush,
        input logic [EXP_W-1:0] exp,
        input string       name
    );
        @(negedge clk);
        dif.InstrD    = instr;
        dif.PCD       = pc;
        dif.PCPlus4D  = pc + 12'd1;
        dif.RegWriteW = rw;
        dif.RdW       = rdw;
        dif.ResultW   = res;
        dif.StallD    = stall;
        dif.FlushE    = flush;
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic report();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        report();
        $finish;
    end

    // ---------------- stimulus ----------------
    logic [EXP_W-1:0] e_stall;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        dif.InstrD    = '0;
        dif.PCD       = '0;
        dif.PCPlus4D  = '0;
        dif.RegWriteW = 1'b0;
        dif.RdW       = '0;
        dif.ResultW   = '0;
        dif.StallD    = 1'b0;
        dif.FlushE    = 1'b0;

        #3;
        check_val("reset_state", act, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // ADD r3,r1,r2
        issue(17'h02624, 12'h010, 0, 4'd0, 16'h0, 0, 0,
              mk(7'b1000000, 3'b000, 16'h0, 16'h0, 16'h0, 4'd3, 4'd1, 4'd2, 12'h010), "add_r3");
        #1;
        check_val("rs2d_add", {90'd0, dif.Rs2D}, {90'd0, 4'd2});
        // ADDI r2,r1,-1 with r1<=5 in flight (bypass)
        issue(17'h0A43F, 12'h011, 1, 4'd1, 16'h0005, 0, 0,
              mk(7'b1001000, 3'b000, 16'h0005, 16'h0, 16'hFFFF, 4'd2, 4'd1, 4'd15, 12'h011), "addi_bypass");
        // Write to r0 ignored, including bypass; rs2=r1 reads 5
        issue(17'h02802, 12'h012, 1, 4'd0, 16'h1234, 0, 0,
              mk(7'b1000000, 3'b000, 16'h0, 16'h0005, 16'h0, 4'd4, 4'd0, 4'd1, 12'h012), "r0_bypass");
        issue(17'h02A00, 12'h013, 0, 4'd0, 16'h0, 0, 0,
              mk(7'b1000000, 3'b000, 16'h0, 16'h0, 16'h0, 4'd5, 4'd0, 4'd0, 12'h013), "r0_read");
        // SUB r6,r1,r1 while writing r7<=00A5
        issue(17'h04C22, 12'h014, 1, 4'd7, 16'h00A5, 0, 0,
              mk(7'b1000000, 3'b001, 16'h0005, 16'h0005, 16'h0, 4'd6, 4'd1, 4'd1, 12'h014), "sub");
        // ST r7 -> [r1+3]: second source from rd field, RdE forced 0
        issue(17'h0EE23, 12'h015, 0, 4'd0, 16'h0, 0, 0,
              mk(7'b0101000, 3'b000, 16'h0005, 16'h00A5, 16'h0003, 4'd0, 4'd1, 4'd7, 12'h015), "st");
        #1;
        check_val("rs2d_st", {90'd0, dif.Rs2D}, {90'd0, 4'd7});
        check_val("rs1d_st", {90'd0, dif.Rs1D}, {90'd0, 4'd1});
        // LD r8,[r1-2]
        issue(17'h0D03E, 12'h016, 0, 4'd0, 16'h0, 0, 0,
              mk(7'b1011000, 3'b000, 16'h0005, 16'h0, 16'hFFFE, 4'd8, 4'd1, 4'd15, 12'h016), "ld");
        // BEQ r1,r7,+4
        issue(17'h10E24, 12'h017, 0, 4'd0, 16'h0, 0, 0,
              mk(7'b0000100, 3'b001, 16'h0005, 16'h00A5, 16'h0004, 4'd0, 4'd1, 4'd7, 12'h017), "beq");
        issue(17'h0722E, 12'h018, 0, 4'd0, 16'h0, 0, 0,
              mk(7'b1000000, 3'b010, 16'h0005, 16'h00A5, 16'h0, 4'd9, 4'd1, 4'd7, 12'h018), "and");
        issue(17'h0942E, 12'h019, 0, 4'd0, 16'h0, 0, 0,
              mk(7'b1000000, 3'b011, 16'h0005, 16'h00A5, 16'h0, 4'd10, 4'd1, 4'd7, 12'h019), "or");
        // Opcode 0xB: illegal, no control bits
        issue(17'h1662E, 12'h01A, 0, 4'd0, 16'h0, 0, 0,
              mk(7'b0000001, 3'b000, 16'h0005, 16'h00A5, 16'h0, 4'd0, 4'd1, 4'd7, 12'h01A), "illegal");
        // JMP imm12=0x800
        issue(17'h12800, 12'h01B, 0, 4'd0, 16'h0, 0, 0,
              mk(7'b0000010, 3'b000, 16'h0, 16'h0, 16'hF800, 4'd0, 4'd0, 4'd0, 12'h01B), "jmp");

        // Stall: capture ADD r3,r1,r7 then hold for two cycles; a write to
        // r11 still lands during the stall.
        e_stall = mk(7'b1000000, 3'b000, 16'h0005, 16'h00A5, 16'h0, 4'd3, 4'd1, 4'd7, 12'h020);
        issue(17'h0262E, 12'h020, 0, 4'd0, 16'h0, 0, 0, e_stall, "stall_load");
        issue(17'h04C22, 12'h030, 1, 4'd11, 16'h0777, 1, 0, e_stall, "stall_hold1");
        issue(17'h0942E, 12'h031, 0, 4'd0, 16'h0, 1, 0, e_stall, "stall_hold2");
        issue(17'h03960, 12'h022, 0, 4'd0, 16'h0, 0, 0,
              mk(7'b1000000, 3'b000, 16'h0777, 16'h0, 16'h0, 4'd12, 4'd11, 4'd0, 12'h022), "write_in_stall");
        // Flush wins over stall
        issue(17'h02624, 12'h023, 0, 4'd0, 16'h0, 1, 1, '0, "flush_stall");
        // Bypass on the second read port
        issue(17'h0841C, 12'h024, 1, 4'd14, 16'h0E0E, 0, 0,
              mk(7'b1000000, 3'b011, 16'h0, 16'h0E0E, 16'h0, 4'd2, 4'd0, 4'd14, 12'h024), "bypass_rs2");
        issue(17'h00000, 12'h025, 0, 4'd0, 16'h0, 0, 0,
              mk(7'b0000000, 3'b000, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 4'd0, 12'h025), "nop");
        issue(17'h0262E, 12'h026, 0, 4'd0, 16'h0, 0, 0,
              mk(7'b1000000, 3'b000, 16'h0005, 16'h00A5, 16'h0, 4'd3, 4'd1, 4'd7, 12'h026), "pre_reset");

        // Asynchronous reset between edges clears E outputs at once.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_val("async_reset", act, '0);
        @(posedge clk);
        #1;
        check_val("reset_hold", act, '0);
        // First capture after release; register file was cleared too.
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(mk(7'b1000000, 3'b000, 16'h0, 16'h0, 16'h0, 4'd3, 4'd1, 4'd7, 12'h026));
        name_q.push_back("first_after_reset");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        report();
        $finish;
    end

endmodule
